// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 encryption AddRoundKey stage.
package aes_pkg;

    // 16-byte AES state; byte [15] is the first byte of the block.
    typedef logic [15:0][7:0] aes_state_t;
    // Round keys share the state layout.
    typedef aes_state_t aes_rkey_t;

    localparam int NR_AES256 = 14;
    localparam int RND_W     = 4;

    // Round sequencing: whitening (IDLE), middle rounds (RUN), final round (FINAL).
    typedef enum logic [1:0] {
        ARK_IDLE  = 2'd0,
        ARK_RUN   = 2'd1,
        ARK_FINAL = 2'd2
    } ark_fsm_e;

endpackage

// File: rtl/mod_enc_ark_keybuf.sv
// Round-key register file: NR+1 slots, one write port, one asynchronous read port.
// Writes to a slot index above NR are dropped and flagged with a one-cycle error pulse.
// The key slots have no reset; only the error flag is cleared by i_rst.
module mod_enc_ark_keybuf #(
    parameter int N     = 16,
    parameter int NR    = 14,
    parameter int RND_W = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [RND_W-1:0]      i_wr_idx,
    input  logic [N-1:0][7:0]     i_wr_data,
    input  logic [RND_W-1:0]      i_rd_idx,
    output logic [N-1:0][7:0]     o_rd_data,
    output logic                  o_wr_err
);

    logic [N-1:0][7:0] r_keys [0:NR];
    logic              r_wr_err;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = (int'(i_wr_idx) <= NR);
    assign w_rd_ok = (int'(i_rd_idx) <= NR);

    // Key slot write; a read of the same slot this cycle still sees the old key.
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_keys[i_wr_idx] <= i_wr_data;
        end
    end

    // One-cycle pulse for an out-of-range write.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= i_wr_en && !w_wr_ok;
        end
    end

    assign o_rd_data = w_rd_ok ? r_keys[i_rd_idx] : '0;
    assign o_wr_err  = r_wr_err;

endmodule

// File: rtl/mod_enc_add_round_key.sv
// AES-256 encryption AddRoundKey stage: XORs the incoming state with rk[rnd],
// registers the result and sequences the round index 0..NR for one block.
// Optional input skid buffer is enabled by defining ARK_SKID_EN.
//
// Handshake: a beat moves on in_valid && in_ready (input side) and on
// out_valid && out_ready (output side); outputs hold steady while
// out_valid && !out_ready. resetn (active high) dominates flush.
module mod_enc_add_round_key #(
    parameter int N     = 16,
    parameter int NR    = 14,
    parameter int RND_W = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  key_wr_en,
    input  logic [RND_W-1:0]      key_wr_idx,
    input  logic [N-1:0][7:0]     key_wr_data,
    output logic                  key_wr_err,
    input  logic                  flush,
    input  logic [N-1:0][7:0]     inp_ark,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N-1:0][7:0]     outp_ark,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RND_W-1:0]      out_rnd,
    output logic                  out_last,
    output logic [RND_W-1:0]      rnd,
    output logic [1:0]            dbg_state
);

    import aes_pkg::*;

    localparam logic [RND_W-1:0] LP_NR    = RND_W'(NR);
    localparam logic [RND_W-1:0] LP_NR_M1 = RND_W'(NR - 1);

    ark_fsm_e          r_state;
    logic [RND_W-1:0]  r_rnd;
    logic [N-1:0][7:0] r_outp;
    logic              r_out_valid;
    logic [RND_W-1:0]  r_out_rnd;
    logic              r_out_last;

    logic [N-1:0][7:0] w_key;
    logic [N-1:0][7:0] w_load_data;
    logic              w_load;
    logic              w_abort;

    assign w_abort = resetn || flush;

    mod_enc_ark_keybuf #(
        .N     (N),
        .NR    (NR),
        .RND_W (RND_W)
    ) u_keybuf (
        .clk       (clk),
        .i_rst     (resetn),
        .i_wr_en   (key_wr_en),
        .i_wr_idx  (key_wr_idx),
        .i_wr_data (key_wr_data),
        .i_rd_idx  (r_rnd),
        .o_rd_data (w_key),
        .o_wr_err  (key_wr_err)
    );

`ifdef ARK_SKID_EN
    logic              r_skid_full;
    logic [N-1:0][7:0] r_skid_data;
    logic              w_out_free;
    logic              w_in_acc;

    assign w_out_free  = !r_out_valid || out_ready;
    // in_ready follows only the registered skid state (plus the abort inputs).
    assign in_ready    = !w_abort && !r_skid_full;
    assign w_in_acc    = in_valid && in_ready;
    assign w_load      = !w_abort && w_out_free && (r_skid_full || w_in_acc);
    assign w_load_data = r_skid_full ? r_skid_data : inp_ark;

    // Skid occupancy: fill when an accepted beat cannot enter the output register.
    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_skid_full <= 1'b0;
        end else if (r_skid_full) begin
            if (w_out_free) begin
                r_skid_full <= 1'b0;
            end
        end else if (w_in_acc && !w_out_free) begin
            r_skid_full <= 1'b1;
        end
    end

    // Skid data capture; contents are only meaningful while r_skid_full.
    always_ff @(posedge clk) begin
        if (!r_skid_full && w_in_acc && !w_out_free) begin
            r_skid_data <= inp_ark;
        end
    end
`else
    assign in_ready    = !w_abort && (!r_out_valid || out_ready);
    assign w_load      = in_valid && in_ready;
    assign w_load_data = inp_ark;
`endif

    // Round sequencing FSM: one step per beat entering the output register.
    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_state <= ARK_IDLE;
            r_rnd   <= '0;
        end else if (w_load) begin
            case (r_state)
                ARK_IDLE: begin
                    r_state <= ARK_RUN;
                    r_rnd   <= RND_W'(1);
                end
                ARK_RUN: begin
                    if (r_rnd == LP_NR_M1) begin
                        r_state <= ARK_FINAL;
                        r_rnd   <= LP_NR;
                    end else begin
                        r_rnd   <= r_rnd + RND_W'(1);
                    end
                end
                ARK_FINAL: begin
                    r_state <= ARK_IDLE;
                    r_rnd   <= '0;
                end
                default: begin
                    r_state <= ARK_IDLE;
                    r_rnd   <= '0;
                end
            endcase
        end
    end

    // Output register: load keyed beat, drop valid after a transfer with no new beat.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_outp      <= '0;
            r_out_valid <= 1'b0;
            r_out_rnd   <= '0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_outp      <= w_load_data ^ w_key;
            r_out_valid <= 1'b1;
            r_out_rnd   <= r_rnd;
            r_out_last  <= (r_rnd == LP_NR);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outp_ark  = r_outp;
    assign out_valid = r_out_valid;
    assign out_rnd   = r_out_rnd;
    assign out_last  = r_out_last;
    assign rnd       = r_rnd;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_enc_add_round_key.sv
// Testbench for mod_enc_add_round_key using the FIPS-197 C.3 AES-256 example.
module tb_mod_enc_add_round_key;
  import aes_pkg::*;

  localparam int NR = 14;
  localparam logic [255:0] CIPHER_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] WHT = 128'h00102030405060708090a0b0c0d0e0f0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn = 1'b1;
  logic             key_wr_en = 1'b0;
  logic [3:0]       key_wr_idx = '0;
  logic [15:0][7:0] key_wr_data = '0;
  logic             key_wr_err;
  logic             flush = 1'b0;
  logic [15:0][7:0] inp_ark = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0][7:0] outp_ark;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [3:0]       out_rnd;
  logic             out_last;
  logic [3:0]       rnd;
  logic [1:0]       dbg_state;

  mod_enc_add_round_key #(.N(16), .NR(NR), .RND_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_wr_err(key_wr_err), .flush(flush),
    .inp_ark(inp_ark), .in_valid(in_valid), .in_ready(in_ready),
    .outp_ark(outp_ark), .out_valid(out_valid), .out_ready(out_ready),
    .out_rnd(out_rnd), .out_last(out_last), .rnd(rnd), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES-256 reference (bench side) ----------------
  logic [7:0]   sbox [256];
  logic [31:0]  w [60];
  logic [127:0] rk [15];
  logic [127:0] st_in [15];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[gb(v, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gb(v, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(v, 4*c); a1 = gb(v, 4*c+1); a2 = gb(v, 4*c+2); a3 = gb(v, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  task automatic build_aes_model();
    logic [7:0] inv, s;
    logic [31:0] t;
    logic [7:0] rc;
    logic [127:0] st;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
    for (int i = 0; i < 8; i++) w[i] = CIPHER_KEY[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i/8 - 1);
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    st_in[0] = PT;
    st = PT ^ rk[0];
    for (int r = 1; r < 14; r++) begin
      st = mix_columns(shift_rows(sub_bytes(st)));
      st_in[r] = st;
      st = st ^ rk[r];
    end
    st = shift_rows(sub_bytes(st));
    st_in[14] = st;
    st = st ^ rk[14];
    check("model_rk0", rk[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("model_rk1", rk[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("model_sbox53", {120'h0, sbox[8'h53]}, 128'hed);
    check("model_ct", st, CT);
  endtask

  // ---------------- scoreboard / compare process ----------------
  // Expected output beats: {data, round, last}.
  logic [132:0] exp_q[$];
  logic         m_init = 1'b0;
  logic [3:0]   m_rnd  = '0;
  logic         m_err  = 1'b0;
  logic [127:0] m_keys [15];
  int           acc_cnt  = 0;
  int           xfer_cnt = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    logic acc;
    logic xfer;
    logic [132:0] e;
    logic [1:0] exp_state;
    exp_rdy = !resetn && !flush && (exp_q.size() == 0 || out_ready);
    if (m_init) begin
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("outp_ark", outp_ark, e[132:5]);
        check("out_rnd", out_rnd, e[4:1]);
        check("out_last", out_last, e[0]);
      end
      check("rnd", rnd, m_rnd);
      check("key_wr_err", key_wr_err, m_err);
      exp_state = (m_rnd == 0) ? ARK_IDLE : ((m_rnd == NR) ? ARK_FINAL : ARK_RUN);
      check("dbg_state", dbg_state, exp_state);
    end
    if (in_valid && in_ready) acc_cnt++;
    if (out_valid && out_ready) xfer_cnt++;
    // advance the model across the coming clock edge
    acc  = in_valid && exp_rdy;
    xfer = (exp_q.size() != 0) && out_ready;
    if (resetn) begin
      exp_q.delete();
      m_rnd  = '0;
      m_init = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      m_rnd = '0;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({inp_ark ^ m_keys[m_rnd], m_rnd, m_rnd == 4'(NR)});
        m_rnd = (m_rnd == 4'(NR)) ? 4'd0 : m_rnd + 4'd1;
      end
    end
    m_err = !resetn && key_wr_en && (key_wr_idx > 4'(NR));
    if (key_wr_en && key_wr_idx <= 4'(NR)) m_keys[key_wr_idx] = key_wr_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_key(input int idx, input logic [127:0] d);
    key_wr_en = 1'b1; key_wr_idx = 4'(idx); key_wr_data = d;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    inp_ark  = d;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (t >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got no in_ready within %0d cycles required 1", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rounds(input int first, input int last);
    for (int r = first; r <= last; r++) send_beat(st_in[r]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_chk++; n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] new_k3;
    logic [127:0] held;
    int a0, x0;
    new_k3 = 128'hdeadbeef0123456789abcdeffedcba98;
    for (int i = 0; i < 15; i++) m_keys[i] = '0;
    build_aes_model();

    // reset state
    tick(2);
    check("rst_outp", outp_ark, 128'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_rnd", out_rnd, 4'd0);
    check("rst_rnd", rnd, 4'd0);
    check("rst_in_ready", in_ready, 1'b0);
    resetn = 1'b0;
    for (int r = 0; r < 15; r++) write_key(r, rk[r]);

    // T1 whitening
    send_beat(PT);
    check("t1_outp", outp_ark, WHT);
    check("t1_out_rnd", out_rnd, 4'd0);
    check("t1_out_last", out_last, 1'b0);
    check("t1_rnd", rnd, 4'd1);
    do_flush();
    check("t1_flush_rnd", rnd, 4'd0);

    // T2 full block
    send_rounds(0, 14);
    check("t2_ct", outp_ark, CT);
    check("t2_out_last", out_last, 1'b1);
    check("t2_out_rnd", out_rnd, 4'd14);
    check("t2_rnd", rnd, 4'd0);
    tick();

    // T3 backpressure
    a0 = acc_cnt; x0 = xfer_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1; inp_ark = st_in[0];
    tick();
    inp_ark = st_in[1];
    held = outp_ark;
    tick(5);
    check("t3_outp_hold", outp_ark, held);
    check("t3_outp_val", outp_ark, st_in[0] ^ rk[0]);
    check("t3_out_rnd_hold", out_rnd, 4'd0);
`ifdef ARK_SKID_EN
    check("t3_acc_stalled", acc_cnt - a0, 2);
`else
    check("t3_acc_stalled", acc_cnt - a0, 1);
`endif
    out_ready = 1'b1;
`ifdef ARK_SKID_EN
    in_valid = 1'b0;
`else
    tick();
    in_valid = 1'b0;
`endif
    tick(3);
    check("t3_acc_total", acc_cnt - a0, 2);
    check("t3_xfer_total", xfer_cnt - x0, 2);
    check("t3_rnd", rnd, 4'd2);
    do_flush();

    // T4 flush at rnd 7 with a beat offered
    send_rounds(0, 6);
    check("t4_rnd7", rnd, 4'd7);
    in_valid = 1'b1; inp_ark = st_in[7]; flush = 1'b1;
    @(negedge clk);
    check("t4_in_ready_flush", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("t4_out_valid", out_valid, 1'b0);
    check("t4_rnd0", rnd, 4'd0);
    send_beat(PT);
    check("t4_rekey_rk0", outp_ark, WHT);
    do_flush();

    // T5 same-slot key write during the round-3 accept
    send_rounds(0, 2);
    key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = new_k3;
    in_valid = 1'b1; inp_ark = st_in[3];
    tick();
    key_wr_en = 1'b0; in_valid = 1'b0;
    check("t5_old_key", outp_ark, st_in[3] ^ rk[3]);
    send_rounds(4, 14);
    check("t5_ct_old", outp_ark, CT);
    send_rounds(0, 3);
    check("t5_new_key", outp_ark, st_in[3] ^ new_k3);
    write_key(3, rk[3]);
    do_flush();

    // T6 out-of-range key write, then mid-block reset
    write_key(15, {4{32'hffffffff}});
    check("t6_err_pulse", key_wr_err, 1'b1);
    tick();
    check("t6_err_clear", key_wr_err, 1'b0);
    send_rounds(0, 14);
    check("t6_ct_keys_intact", outp_ark, CT);
    tick();
    send_rounds(0, 4);
    in_valid = 1'b1; inp_ark = st_in[5]; resetn = 1'b1;
    @(negedge clk);
    check("t6_in_ready_rst", in_ready, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0; in_valid = 1'b0;
    check("t6_rst_outp", outp_ark, 128'h0);
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_out_rnd", out_rnd, 4'd0);
    check("t6_rst_out_last", out_last, 1'b0);
    check("t6_rst_rnd", rnd, 4'd0);
    send_beat(PT);
    check("t6_after_rst", outp_ark, WHT);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
